lfsr: RTL and testbench
=======================

LFSR -- requirements
Module: lfsr

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 Parameter WIDTH, default 4: register width; legal range 2..32.
REQ-003 Parameter SEED, default 1 (4'b0001): value loaded on reset; a SEED of 0 SHALL be replaced by 1.
REQ-004 Parameter MODE, default FIBONACCI: feedback topology, either FIBONACCI or GALOIS.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port op, output, WIDTH bits: current LFSR state, driven directly from the state register.

Function
REQ-008 The state SHALL advance exactly once per rising clk edge while rst is low; there is no enable and no stall.
REQ-009 op SHALL equal the register contents (zero combinational latency); the first new value appears on the first rising edge after rst deasserts.
REQ-010 The tap set SHALL be the maximal-length polynomial for WIDTH, taken from the package table; WIDTH=4 uses x^4+x^3+1 (taps at bits 3 and 2).
REQ-011 In FIBONACCI mode: fb = XOR of the tapped op bits; next op = {op[WIDTH-2:0], fb} (shift toward MSB, feedback into bit 0).
REQ-012 In GALOIS mode: next op = (op << 1) XOR (POLY_LOW when op[WIDTH-1]=1, else 0); POLY_LOW is the polynomial without its x^WIDTH term (4'b1001 for WIDTH=4).
REQ-013 The sequence period SHALL be 2^WIDTH-1 (15 for WIDTH=4) in both modes.
REQ-014 The all-zero state SHALL never persist: if op is all zeros at a clock edge (fault or upset), the next state SHALL be the effective SEED.
REQ-015 WIDTH=4, FIBONACCI, SEED=1 sequence: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then back to 0001.
REQ-016 Illegal WIDTH (outside 2..32) SHALL be rejected at elaboration with a fatal message.

Reset
REQ-017 rst high SHALL force op to the effective SEED immediately, independent of clk.
REQ-018 op SHALL hold the effective SEED for as long as rst stays high; clock edges during reset are ignored.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence; after release, the sequence restarts from SEED.
REQ-020 rst SHALL be the only reset; there is no synchronous clear.

Structure
REQ-021 Package lfsr_pkg SHALL hold: the MODE enum (FIBONACCI, GALOIS); the maximal-length tap-mask table for WIDTH 2..32; and a function returning the Fibonacci tap mask and the Galois POLY_LOW for a given WIDTH.
REQ-022 A single combinational sub-module, lfsr_next, SHALL compute the next state from the current state, WIDTH and MODE, including the zero-state recovery.
REQ-023 The top module lfsr SHALL contain only the state register, the reset logic, the parameter checks and the lfsr_next instance.

Verification
REQ-024 Hold rst=1 with clk toggling every 2 ns -> op=0001 throughout.
REQ-025 Release rst at 5 ns with WIDTH=4, FIBONACCI -> after successive edges op = 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110.
REQ-026 Run 15 edges after reset -> op returns to 0001; all 15 nonzero values appear exactly once.
REQ-027 Assert rst asynchronously between edges while op=1101 -> op=0001 before the next clk edge; on release the sequence restarts at 0010.
REQ-028 Force the state to 0000 -> op=0001 after the next edge; separately, SEED=0 -> reset value 0001.
REQ-029 Sweep WIDTH over {2, 8, 16} in both modes -> measured period equals 2^WIDTH-1 with no all-zero state.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: feedback topology, maximal-length tap table and
// a helper that derives the Fibonacci tap mask and Galois POLY_LOW per width.
package lfsr_pkg;

    typedef enum logic {
        FIBONACCI = 1'b0,
        GALOIS    = 1'b1
    } lfsr_mode_e;

    localparam int unsigned LFSR_MIN_W = 2;
    localparam int unsigned LFSR_MAX_W = 32;

    // Bit k set means x^(k+1) appears in the primitive polynomial; entries 0..1 unused.
    localparam logic [31:0] LFSR_TAPS [0:32] = '{
        32'h0000_0000, 32'h0000_0000,
        32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
        32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
        32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
        32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
        32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
        32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
        32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
        32'h2000_0029, 32'h4800_0000, 32'h8020_0003
    };

    typedef struct packed {
        logic [31:0] fib_mask;
        logic [31:0] poly_low;
    } lfsr_poly_t;

    // Galois POLY_LOW is the same polynomial re-indexed by exponent, with the
    // x^w term dropped and the constant term added.
    function automatic lfsr_poly_t lfsr_poly(input int unsigned w);
        lfsr_poly_t  p;
        logic [5:0]  idx;
        logic [31:0] mask;
        p   = '0;
        idx = w[5:0];
        if (w >= LFSR_MIN_W && w <= LFSR_MAX_W) begin
            mask       = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            p.fib_mask = LFSR_TAPS[idx];
            p.poly_low = ((p.fib_mask << 1) & mask) | 32'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state logic for the LFSR, in either topology, with
// recovery from the lock-up all-zero state.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned          WIDTH = 4,
    parameter lfsr_mode_e           MODE  = FIBONACCI,
    parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    localparam lfsr_poly_t       POLY     = lfsr_poly(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = POLY.fib_mask[WIDTH-1:0];
    localparam logic [WIDTH-1:0] POLY_LOW = POLY.poly_low[WIDTH-1:0];

    logic w_fb;

    assign w_fb = ^(i_state & TAPS);

    always_comb begin
        o_next = SEED;
        if (i_state != '0) begin
            if (MODE == FIBONACCI) begin
                o_next = {i_state[WIDTH-2:0], w_fb};
            end else begin
                o_next = (i_state << 1) ^ (i_state[WIDTH-1] ? POLY_LOW : '0);
            end
        end
    end

endmodule

// File: rtl/lfsr.sv
// Free-running maximal-length LFSR: one state register, advanced every clock
// while out of reset; op is the register itself.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter lfsr_mode_e       MODE  = FIBONACCI
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] op
);

    // A zero seed would lock the register, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
        $fatal(1, "lfsr: WIDTH=%0d outside supported range 2..32", WIDTH);
    end

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    lfsr_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .SEED  (SEED_EFF)
    ) u_next (
        .i_state (r_state),
        .o_next  (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED_EFF;
        end else begin
            r_state <= w_next;
        end
    end

    assign op = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: reset behaviour, the WIDTH=4 sequences, async
// reset mid-run, zero-state recovery, SEED=0 and period sweeps.
`timescale 1ns/100ps
module tb_lfsr;
    import lfsr_pkg::*;

    logic clk;
    logic rst;
    logic rst_s;

    logic [3:0]  op_fib4;
    logic [3:0]  op_gal4;
    logic [3:0]  op_z4;
    logic [1:0]  op_f2, op_g2;
    logic [7:0]  op_f8, op_g8;
    logic [15:0] op_f16, op_g16;
    logic [3:0]  nx_in, nx_out;
    logic [31:0] sw_op [6];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #2 clk = ~clk;

    lfsr #(.WIDTH(4), .SEED(4'd1), .MODE(FIBONACCI)) dut (.clk(clk), .rst(rst), .op(op_fib4));
    lfsr #(.WIDTH(4), .SEED(4'd1), .MODE(GALOIS))    u_gal4 (.clk(clk), .rst(rst), .op(op_gal4));
    lfsr #(.WIDTH(4), .SEED(4'd0), .MODE(FIBONACCI)) u_zseed (.clk(clk), .rst(rst), .op(op_z4));

    lfsr #(.WIDTH(2),  .SEED(2'd1),  .MODE(FIBONACCI)) u_f2  (.clk(clk), .rst(rst_s), .op(op_f2));
    lfsr #(.WIDTH(2),  .SEED(2'd1),  .MODE(GALOIS))    u_g2  (.clk(clk), .rst(rst_s), .op(op_g2));
    lfsr #(.WIDTH(8),  .SEED(8'd1),  .MODE(FIBONACCI)) u_f8  (.clk(clk), .rst(rst_s), .op(op_f8));
    lfsr #(.WIDTH(8),  .SEED(8'd1),  .MODE(GALOIS))    u_g8  (.clk(clk), .rst(rst_s), .op(op_g8));
    lfsr #(.WIDTH(16), .SEED(16'd1), .MODE(FIBONACCI)) u_f16 (.clk(clk), .rst(rst_s), .op(op_f16));
    lfsr #(.WIDTH(16), .SEED(16'd1), .MODE(GALOIS))    u_g16 (.clk(clk), .rst(rst_s), .op(op_g16));

    lfsr_next #(.WIDTH(4), .MODE(FIBONACCI), .SEED(4'd1)) u_nx (.i_state(nx_in), .o_next(nx_out));

    assign sw_op[0] = 32'(op_f2);
    assign sw_op[1] = 32'(op_g2);
    assign sw_op[2] = 32'(op_f8);
    assign sw_op[3] = 32'(op_g8);
    assign sw_op[4] = 32'(op_f16);
    assign sw_op[5] = 32'(op_g16);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] fib_exp [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] gal_exp [7]  = '{4'b0010, 4'b0100, 4'b1000, 4'b1001,
                                 4'b1011, 4'b1111, 4'b0111};
    int unsigned per_exp [6] = '{3, 3, 255, 255, 65535, 65535};

    initial begin
        logic [15:0]  seen;
        int           n_seen;
        int unsigned  period [6];
        int unsigned  zeros [6];
        bit           done [6];
        bit           all_done;

        rst   = 1'b1;
        rst_s = 1'b1;
        nx_in = 4'b0000;
        seen  = '0;

        #1;
        check_val("reset_op", 32'(op_fib4), 32'h1);
        check_val("seed0_reset", 32'(op_z4), 32'h1);
        @(posedge clk);
        #1;
        check_val("reset_hold_edge", 32'(op_fib4), 32'h1);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("fib4_step%0d", i + 1), 32'(op_fib4), 32'(fib_exp[i]));
            if (i < 7) check_val($sformatf("gal4_step%0d", i + 1), 32'(op_gal4), 32'(gal_exp[i]));
            if (i == 0) check_val("seed0_first", 32'(op_z4), 32'h2);
            seen[op_fib4] = 1'b1;
        end
        n_seen = 0;
        for (int v = 0; v < 16; v++) if (seen[v]) n_seen++;
        check_val("fib4_distinct", 32'(n_seen), 32'd15);
        check_val("fib4_no_zero", 32'(seen[0]), 32'd0);

        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        check_val("pre_async_op", 32'(op_fib4), 32'hD);
        @(negedge clk);
        #0.5;
        rst = 1'b1;
        #0.5;
        check_val("async_reset", 32'(op_fib4), 32'h1);
        @(posedge clk);
        #1;
        check_val("async_hold", 32'(op_fib4), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("restart_first", 32'(op_fib4), 32'h2);

        nx_in = 4'b0000;
        #1;
        check_val("zero_recover", 32'(nx_out), 32'h1);
        nx_in = 4'b1101;
        #1;
        check_val("next_of_1101", 32'(nx_out), 32'hA);

        for (int k = 0; k < 6; k++) begin
            period[k] = 0;
            zeros[k]  = 0;
            done[k]   = 1'b0;
        end
        @(negedge clk);
        rst_s = 1'b0;
        for (int cyc = 1; cyc <= 70000; cyc++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (!done[k]) begin
                    if (sw_op[k] == 32'd0) zeros[k]++;
                    if (sw_op[k] == 32'd1) begin
                        period[k] = cyc;
                        done[k]   = 1'b1;
                    end
                end
                all_done = all_done & done[k];
            end
            if (all_done) break;
        end
        for (int k = 0; k < 6; k++) begin
            check_val($sformatf("sweep%0d_period", k), 32'(period[k]), 32'(per_exp[k]));
            check_val($sformatf("sweep%0d_zeros", k), 32'(zeros[k]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
